// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared definitions for the iterative AES inverse cipher: round counts, FSM states
// and the GF(2^8) helpers behind InvShiftRows and InvMixColumns.
package aes_inv_cipher_iter_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiply by x modulo the AES polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

    // Byte n = row + 4*col sits at [127-8n -: 8]; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box as a plain combinational lookup table.
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock. The key schedule is read live
// from AllKeys, so the caller must hold it stable until the plaintext is delivered.
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_block,
    input  logic [128*(NR+1)-1:0] AllKeys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_block,
    output logic                  busy
);

    localparam int RW = $clog2(NR + 1);

    state_t          r_state;
    logic [RW-1:0]   r_rnd;
    logic [127:0]    r_st;
    logic [127:0]    w_shifted;
    logic [127:0]    w_subbed;
    logic [127:0]    w_roundKey;
    logic [127:0]    w_addKey;
    logic [127:0]    w_mixed;

    assign w_shifted = inv_shift_rows(r_st);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .i_byte (w_shifted[8*g +: 8]),
            .o_byte (w_subbed[8*g +: 8])
        );
    end

    // rk[i] lives at AllKeys[128*(NR-i) +: 128]; rk[NR] is only needed at accept.
    always_comb begin
        w_roundKey = '0;
        for (int i = 0; i < NR; i++)
            if (r_rnd == RW'(i))
                w_roundKey = AllKeys[128*(NR-i) +: 128];
    end

    assign w_addKey = w_subbed ^ w_roundKey;

    always_comb begin
        w_mixed = '0;
        for (int c = 0; c < 4; c++)
            w_mixed[127-32*c -: 32] = inv_mix_column(w_addKey[127-32*c -: 32]);
    end

    // The final round skips InvMixColumns and latches the plaintext for the consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rnd     <= '0;
            r_st      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_block <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_st     <= in_block ^ AllKeys[127:0];
                        r_rnd    <= RW'(NR - 1);
                        r_state  <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_rnd != '0) begin
                        r_st  <= w_mixed;
                        r_rnd <= r_rnd - RW'(1);
                    end else begin
                        r_st      <= w_addKey;
                        out_block <= w_addKey;
                        out_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: three instances (AES-128/192/256) checked against a
// forward-cipher reference model and the FIPS-197 example vectors.
module tb_aes_inv_cipher_iter;
    import aes_inv_cipher_iter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [2:0]        inV;
    logic [2:0]        outR;
    logic [2:0][127:0] inB;
    wire  [2:0]        inRdy;
    wire  [2:0]        outV;
    wire  [2:0]        bsy;
    wire  [2:0][127:0] outB;
    logic [128*11-1:0] keys10;
    logic [128*13-1:0] keys12;
    logic [128*15-1:0] keys14;
    logic [128*15-1:0] ks;
    logic [7:0]        sboxT [256];
    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NR(NR_128)) u_dut10 (
        .clk(clk), .reset(reset), .in_valid(inV[0]), .in_ready(inRdy[0]), .in_block(inB[0]),
        .AllKeys(keys10), .out_valid(outV[0]), .out_ready(outR[0]), .out_block(outB[0]), .busy(bsy[0]));
    aes_inv_cipher_iter #(.NR(NR_192)) u_dut12 (
        .clk(clk), .reset(reset), .in_valid(inV[1]), .in_ready(inRdy[1]), .in_block(inB[1]),
        .AllKeys(keys12), .out_valid(outV[1]), .out_ready(outR[1]), .out_block(outB[1]), .busy(bsy[1]));
    aes_inv_cipher_iter #(.NR(NR_256)) u_dut14 (
        .clk(clk), .reset(reset), .in_valid(inV[2]), .in_ready(inRdy[2]), .in_block(inB[2]),
        .AllKeys(keys14), .out_valid(outV[2]), .out_ready(outR[2]), .out_block(outB[2]), .busy(bsy[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from first principles: multiplicative inverse, then the affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sboxT[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
    endfunction

    // Key in the MSBs of a 256-bit value; result holds {rk0..rkNR} in its low bits.
    function automatic logic [128*15-1:0] expandKey(input logic [255:0] key, input int nk);
        logic [31:0]        w [60];
        logic [31:0]        t;
        logic [7:0]         rcon = 8'h01;
        logic [128*15-1:0]  res = '0;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) res = {res[128*15-33:0], w[i]};
        return res;
    endfunction

    function automatic logic [127:0] encryptRef(input logic [127:0] pt, input logic [128*15-1:0] k,
                                                input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ k[128*nr +: 128];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int n = 0; n < 16; n++) s[n] = sboxT[v[127-8*n -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
                t = s;
            end
            for (int n = 0; n < 16; n++) v[127-8*n -: 8] = t[n];
            v ^= k[128*(nr-rnd) +: 128];
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic loadKeys(input int idx, input logic [128*15-1:0] k);
        case (idx)
            0:       keys10 = k[128*11-1:0];
            1:       keys12 = k[128*13-1:0];
            default: keys14 = k;
        endcase
    endtask

    // Accept one block, measure latency, optionally complete the output handshake.
    task automatic applyStimulus(input int idx, input logic [127:0] ct, input logic [127:0] pt,
                                 input int nr, input string tag, input bit handshake);
        int waitCycles = 0;
        int edges = 0;
        while (!inRdy[idx] && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        checkOutput({tag, "_ready"}, 128'(inRdy[idx]), 128'd1);
        inB[idx] = ct;
        inV[idx] = 1'b1;
        tick();
        inV[idx] = 1'b0;
        checkOutput({tag, "_acceptBusy"}, {126'd0, inRdy[idx], bsy[idx]}, 128'b01);
        while (edges < 40) begin
            tick();
            edges++;
            if (outV[idx]) break;
        end
        checkOutput({tag, "_latency"}, 128'(edges), 128'(nr));
        checkOutput({tag, "_plain"}, outB[idx], pt);
        if (handshake) begin
            outR[idx] = 1'b1;
            tick();
            outR[idx] = 1'b0;
            checkOutput({tag, "_release"}, {125'd0, outV[idx], inRdy[idx], bsy[idx]}, 128'b010);
            checkOutput({tag, "_keep"}, outB[idx], pt);
        end
    endtask

    task automatic runRandom(input int idx, input int nr, input int nk, input string tag);
        logic [127:0] pt;
        logic [128*15-1:0] k;
        k = expandKey({rand128(), rand128()}, nk);
        loadKeys(idx, k);
        pt = rand128();
        applyStimulus(idx, encryptRef(pt, k, nr), pt, nr, tag, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] pt;
        logic [127:0] bPt [3];
        logic [127:0] bCt [3];
        int accepts [$];
        logic [127:0] got [$];
        bit prevReady;
        int cycle;

        inV = '0;
        outR = '0;
        inB = '0;
        buildSbox();
        loadKeys(0, expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4));
        loadKeys(1, expandKey({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6));
        loadKeys(2, expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8));

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", {125'd0, inRdy[0], outV[0], bsy[0]}, 128'b100);
        checkOutput("reset_block", outB[0], 128'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        applyStimulus(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, FIPS_PT, NR_128, "fips128", 1'b1);
        applyStimulus(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, FIPS_PT, NR_192, "fips192", 1'b1);
        applyStimulus(2, 128'h8ea2b7ca516745bfeafc49904b496089, FIPS_PT, NR_256, "fips256", 1'b1);

        for (int i = 0; i < 3; i++) runRandom(0, NR_128, 4, "rand128");
        runRandom(1, NR_192, 6, "rand192");
        runRandom(2, NR_256, 8, "rand256");

        $display("[TB] backpressure in DONE");
        ks = expandKey({rand128(), rand128()}, 4);
        loadKeys(0, ks);
        pt = rand128();
        applyStimulus(0, encryptRef(pt, ks, NR_128), pt, NR_128, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            inV[0] = 1'b1;
            inB[0] = rand128();
            tick();
            checkOutput("bp_hold_flags", {126'd0, outV[0], inRdy[0]}, 128'b10);
            checkOutput("bp_hold_block", outB[0], pt);
        end
        inV[0] = 1'b0;
        outR[0] = 1'b1;
        tick();
        outR[0] = 1'b0;
        checkOutput("bp_release", {126'd0, outV[0], inRdy[0]}, 128'b01);
        pt = rand128();
        applyStimulus(0, encryptRef(pt, ks, NR_128), pt, NR_128, "bp_second", 1'b1);

        $display("[TB] reset during RUN");
        loadKeys(0, expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4));
        inB[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        inV[0] = 1'b1;
        tick();
        inV[0] = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_flags", {125'd0, outV[0], inRdy[0], bsy[0]}, 128'b010);
        @(negedge clk) reset = 1'b1;
        tick();
        applyStimulus(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, FIPS_PT, NR_128, "rerun", 1'b1);

        $display("[TB] back-to-back blocks");
        ks = expandKey({rand128(), rand128()}, 4);
        loadKeys(0, ks);
        for (int j = 0; j < 3; j++) begin
            bPt[j] = rand128();
            bCt[j] = encryptRef(bPt[j], ks, NR_128);
        end
        inB[0] = bCt[0];
        inV[0] = 1'b1;
        outR[0] = 1'b1;
        prevReady = inRdy[0];
        cycle = 0;
        while (got.size() < 3 && cycle < 200) begin
            tick();
            cycle++;
            if (prevReady && inV[0]) begin
                accepts.push_back(cycle);
                if (accepts.size() < 3) inB[0] = bCt[accepts.size()];
                else inV[0] = 1'b0;
            end
            if (outV[0]) got.push_back(outB[0]);
            prevReady = inRdy[0];
        end
        inV[0] = 1'b0;
        outR[0] = 1'b0;
        checkOutput("b2b_count", 128'(got.size()), 128'd3);
        for (int j = 0; j < 3; j++)
            checkOutput("b2b_plain", (j < got.size()) ? got[j] : 128'hx, bPt[j]);
        for (int j = 1; j < 3; j++)
            checkOutput("b2b_spacing",
                        (j < accepts.size()) ? 128'(accepts[j] - accepts[j-1]) : 128'hx,
                        128'(NR_128 + 2));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
